// File: rtl/pong_pkg.sv
// Shared Pong constants: speed band encodings, joystick thresholds,
// paddle speeds and playfield geometry used by the paddle, renderer and LEDs.
package pong_pkg;

    typedef enum logic [2:0] {
        BAND_FAST_UP = 3'd0,
        BAND_SLOW_UP = 3'd1,
        BAND_DEAD    = 3'd2,
        BAND_SLOW_DN = 3'd3,
        BAND_FAST_DN = 3'd4
    } band_e;

    localparam logic [9:0] TH_FAST_UP = 10'h2F0;
    localparam logic [9:0] TH_SLOW_UP = 10'h220;
    localparam logic [9:0] TH_SLOW_DN = 10'h180;
    localparam logic [9:0] TH_FAST_DN = 10'h0A0;

    localparam int SPD_SLOW = 2;
    localparam int SPD_FAST = 6;

    localparam logic [9:0] PAD_MIN  = 10'd0;
    localparam logic [9:0] PAD_MAX  = 10'd400;
    localparam logic [9:0] PAD_INIT = 10'd200;

    localparam logic [9:0] Y_CENTER = 10'h200;

endpackage

// File: rtl/sample_averager.sv
// Boxcar averager: sums 2^AVG_LOG2 valid samples, then publishes the
// truncated mean and restarts the window.
module sample_averager #(
    parameter int         W         = 10,
    parameter int         AVG_LOG2  = 2,
    parameter logic [9:0] FILT_INIT = 10'h200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic [W-1:0] dout
);

    localparam int AW = W + AVG_LOG2;

    logic [AW-1:0]       acc_q, acc_d;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [W-1:0]        filt_q, filt_d;
    logic [AW-1:0]       sum;

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        filt_d = filt_q;
        sum    = acc_q + AW'(din);
        if (din_valid) begin
            if (&cnt_q) begin
                filt_d = sum[AW-1:AVG_LOG2];
                acc_d  = '0;
                cnt_d  = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            filt_q <= W'(FILT_INIT);
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/joystick_paddle_ctrl.sv
// Joystick Y to Pong paddle row: averaged sample, five speed bands,
// per-frame integration clamped to the playfield.
module joystick_paddle_ctrl
    import pong_pkg::*;
#(
    parameter int         AVG_LOG2 = 2,
    parameter logic [9:0] TH_FU    = TH_FAST_UP,
    parameter logic [9:0] TH_SU    = TH_SLOW_UP,
    parameter logic [9:0] TH_SD    = TH_SLOW_DN,
    parameter logic [9:0] TH_FD    = TH_FAST_DN,
    parameter int         SPD_S    = SPD_SLOW,
    parameter int         SPD_F    = SPD_FAST,
    parameter logic [9:0] P_MIN    = PAD_MIN,
    parameter logic [9:0] P_MAX    = PAD_MAX,
    parameter logic [9:0] P_INIT   = PAD_INIT
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic [9:0] y_in,
    input  logic       y_valid,
    input  logic       frame_tick,
    output logic [9:0] paddle_y,
    output logic [2:0] band,
    output logic [9:0] y_filt,
    output logic       moving_up,
    output logic       moving_down
);

    localparam logic signed [11:0] STEP_S = 12'(SPD_S);
    localparam logic signed [11:0] STEP_F = 12'(SPD_F);

    logic [2:0]        band_q, band_d;
    logic [9:0]        pad_q, pad_d;
    logic              up_q, up_d;
    logic              dn_q, dn_d;
    logic signed [11:0] step;
    logic signed [11:0] pos_raw;
    logic [9:0]        pos_clamped;

    sample_averager #(
        .W        (10),
        .AVG_LOG2 (AVG_LOG2),
        .FILT_INIT(Y_CENTER)
    ) u_avg (
        .clk      (clk50M),
        .rst      (rst),
        .din      (y_in),
        .din_valid(y_valid),
        .dout     (y_filt)
    );

    always_comb begin
        band_d = BAND_FAST_DN;
        if (y_filt >= TH_FU)      band_d = BAND_FAST_UP;
        else if (y_filt >= TH_SU) band_d = BAND_SLOW_UP;
        else if (y_filt >= TH_SD) band_d = BAND_DEAD;
        else if (y_filt >= TH_FD) band_d = BAND_SLOW_DN;
    end

    // Signed 12-bit so a step above row 0 goes negative instead of wrapping.
    always_comb begin
        step = '0;
        case (band_q)
            BAND_FAST_UP: step = -STEP_F;
            BAND_SLOW_UP: step = -STEP_S;
            BAND_SLOW_DN: step = STEP_S;
            BAND_FAST_DN: step = STEP_F;
            default:      step = '0;
        endcase
        pos_raw = $signed({2'b00, pad_q}) + step;
        if (pos_raw < $signed({2'b00, P_MIN}))
            pos_clamped = P_MIN;
        else if (pos_raw > $signed({2'b00, P_MAX}))
            pos_clamped = P_MAX;
        else
            pos_clamped = pos_raw[9:0];
    end

    always_comb begin
        pad_d = pad_q;
        up_d  = up_q;
        dn_d  = dn_q;
        if (frame_tick) begin
            pad_d = pos_clamped;
            up_d  = pos_clamped < pad_q;
            dn_d  = pos_clamped > pad_q;
        end
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            band_q <= BAND_DEAD;
            pad_q  <= P_INIT;
            up_q   <= 1'b0;
            dn_q   <= 1'b0;
        end else begin
            band_q <= band_d;
            pad_q  <= pad_d;
            up_q   <= up_d;
            dn_q   <= dn_d;
        end
    end

    assign paddle_y    = pad_q;
    assign band        = band_q;
    assign moving_up   = up_q;
    assign moving_down = dn_q;

endmodule

// File: tb/tb_joystick_paddle_ctrl.sv
// Directed bench for joystick_paddle_ctrl: filter, bands, clamping,
// coincident frame/sample and reset mid-window.
module tb_joystick_paddle_ctrl;

    logic       clk50M = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] y_in = '0;
    logic       y_valid = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] paddle_y;
    logic [2:0] band;
    logic [9:0] y_filt;
    logic       moving_up;
    logic       moving_down;

    int n_cmp = 0;
    int n_bad = 0;

    joystick_paddle_ctrl dut (
        .clk50M     (clk50M),
        .rst        (rst),
        .y_in       (y_in),
        .y_valid    (y_valid),
        .frame_tick (frame_tick),
        .paddle_y   (paddle_y),
        .band       (band),
        .y_filt     (y_filt),
        .moving_up  (moving_up),
        .moving_down(moving_down)
    );

    always #10 clk50M = ~clk50M;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk50M);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
    endtask

    task automatic sample(input logic [9:0] v);
        y_in    = v;
        y_valid = 1'b1;
        step_clk();
        y_valid = 1'b0;
    endtask

    task automatic window(input logic [9:0] v);
        for (int i = 0; i < 4; i++) sample(v);
        step_clk();
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step_clk();
        frame_tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step_clk();
        step_clk();
        rst = 1'b0;
        step_clk();

        check("rst_paddle", paddle_y, 200);
        check("rst_band", band, 2);
        check("rst_yfilt", y_filt, 10'h200);
        check("rst_up", moving_up, 0);
        check("rst_dn", moving_down, 0);

        for (int i = 0; i < 4; i++) sample(10'h300);
        check("avg_300", y_filt, 10'h300);
        check("band_pre", band, 2);
        step_clk();
        check("band_fu", band, 0);
        frame();
        check("fu_1", paddle_y, 194);
        frame();
        check("fu_2", paddle_y, 188);
        frame();
        check("fu_3", paddle_y, 182);
        check("fu_up", moving_up, 1);
        check("fu_dn", moving_down, 0);

        do_reset();
        sample(10'h0A0);
        sample(10'h0A0);
        sample(10'h0A0);
        sample(10'h0A3);
        check("avg_a0", y_filt, 10'h0A0);
        step_clk();
        check("band_th", band, 3);
        frame();
        check("sd_1", paddle_y, 202);
        check("sd_dn", moving_down, 1);
        check("sd_up", moving_up, 0);

        do_reset();
        window(10'h250);
        check("band_su", band, 1);
        for (int i = 0; i < 98; i++) frame();
        check("at_4", paddle_y, 4);
        window(10'h300);
        frame();
        check("clamp_lo", paddle_y, 0);
        check("clamp_lo_up", moving_up, 1);
        frame();
        check("hold_lo", paddle_y, 0);
        check("hold_lo_up", moving_up, 0);
        check("hold_lo_dn", moving_down, 0);

        window(10'h100);
        check("band_sd", band, 3);
        for (int i = 0; i < 199; i++) frame();
        check("at_398", paddle_y, 398);
        window(10'h050);
        check("band_fd", band, 4);
        frame();
        check("clamp_hi", paddle_y, 400);
        check("clamp_hi_dn", moving_down, 1);
        frame();
        check("hold_hi", paddle_y, 400);
        check("hold_hi_dn", moving_down, 0);
        check("hold_hi_up", moving_up, 0);

        do_reset();
        sample(10'h3FF);
        sample(10'h3FF);
        sample(10'h3FF);
        y_in       = 10'h3FF;
        y_valid    = 1'b1;
        frame_tick = 1'b1;
        step_clk();
        y_valid    = 1'b0;
        frame_tick = 1'b0;
        check("co_paddle", paddle_y, 200);
        check("co_up", moving_up, 0);
        check("co_yfilt", y_filt, 10'h3FF);
        check("co_band_old", band, 2);
        step_clk();
        check("co_band_new", band, 0);
        frame();
        check("co_next", paddle_y, 194);

        sample(10'h3FF);
        sample(10'h3FF);
        do_reset();
        for (int i = 0; i < 4; i++) sample(10'h180);
        check("rs_yfilt", y_filt, 10'h180);
        step_clk();
        check("rs_band", band, 2);
        frame();
        frame();
        check("rs_paddle", paddle_y, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
